// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit arbiter.
package uart_pkg;

   localparam int unsigned UART_DATA_W         = 8;
   localparam int unsigned DEFAULT_ACK_TIMEOUT = 256;
   localparam int unsigned DEFAULT_GAP_CYCLES  = 32;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StGrant = 3'd1,
      StStart = 3'd2,
      StBusy  = 3'd3,
      StGap   = 3'd4
   } tx_state_e;

   // Round-robin pointer value following a grant of idx among n requesters.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, cyclically.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic                       any,
   output logic [$clog2(NUM_REQ)-1:0] winner
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   // Scan from the farthest offset back to the pointer so the nearest set bit wins.
   always_comb begin
      int unsigned idx;
      idx    = 0;
      any    = 1'b0;
      winner = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx = (32'(ptr) + 32'(off)) % NUM_REQ;
         if (req[idx[IdxW-1:0]]) begin
            any    = 1'b1;
            winner = idx[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end sharing one UART transmitter among several byte producers.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_W      = UART_DATA_W,
   parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
   parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
   input  logic                        sys_clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_odd,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        tx_enable,
   output logic [DATA_W-1:0]           tx_data,
   output logic                        even_odd,
   input  logic                        busy_tx,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        frame_done,
   output logic                        timeout_err
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned ToW  = $clog2(ACK_TIMEOUT) + 1;
   localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

   localparam logic [ToW-1:0]  ToLast  = ToW'(ACK_TIMEOUT - 1);
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

   tx_state_e          state;
   logic [IdxW-1:0]    ptr;
   logic [ToW-1:0]     to_cnt;
   logic [GapW-1:0]    gap_cnt;
   logic               busy_meta;
   logic               busy_s;
   logic               arb_any;
   logic [IdxW-1:0]    arb_winner;
   logic [DATA_W-1:0]  req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
      assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req    (req_valid),
      .ptr    (ptr),
      .any    (arb_any),
      .winner (arb_winner)
   );

   // Two-flop synchronizer for the transmitter's busy flag (baud-clock domain).
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         busy_meta <= 1'b0;
         busy_s    <= 1'b0;
      end else begin
         busy_meta <= busy_tx;
         busy_s    <= busy_meta;
      end
   end

   // Frame sequencing FSM with registered handshake, transmitter and status outputs.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state       <= StIdle;
         ptr         <= '0;
         grant_id    <= '0;
         req_ready   <= '0;
         tx_enable   <= 1'b0;
         tx_data     <= '0;
         even_odd    <= 1'b0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         to_cnt      <= '0;
         gap_cnt     <= '0;
      end else begin
         req_ready   <= '0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            StIdle: begin
               if (arb_any) begin
                  grant_id  <= arb_winner;
                  req_ready <= NUM_REQ'(1) << arb_winner;
                  state     <= StGrant;
               end
            end
            StGrant: begin
               // Requester still holds its byte while ready is high, so capture here.
               tx_data   <= req_bytes[grant_id];
               even_odd  <= req_odd[grant_id];
               ptr       <= IdxW'(rr_next(32'(grant_id), NUM_REQ));
               to_cnt    <= '0;
               tx_enable <= 1'b1;
               state     <= StStart;
            end
            StStart: begin
               // A busy rise takes priority over a simultaneous timeout expiry.
               if (busy_s) begin
                  tx_enable <= 1'b0;
                  state     <= StBusy;
               end else if (to_cnt == ToLast) begin
                  tx_enable   <= 1'b0;
                  timeout_err <= 1'b1;
                  gap_cnt     <= '0;
                  state       <= StGap;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            StBusy: begin
               if (!busy_s) begin
                  frame_done <= 1'b1;
                  gap_cnt    <= '0;
                  state      <= StGap;
               end
            end
            StGap: begin
               if (gap_cnt == GapLast) begin
                  state <= StIdle;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a behavioural transmitter.
module tb_uart_tx_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned ACK   = 64;
   localparam int unsigned GAP   = 8;
   localparam int unsigned FRAME = 20;

   localparam int SigTxEn   = 0;
   localparam int SigTxLow  = 1;
   localparam int SigFrame  = 2;
   localparam int SigTmo    = 3;

   logic            sys_clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_odd;
   logic [N-1:0]    req_ready;
   logic            tx_enable;
   logic [DW-1:0]   tx_data;
   logic            even_odd;
   logic            busy_tx = 1'b0;
   logic [1:0]      grant_id;
   logic            frame_done;
   logic            timeout_err;

   logic [DW-1:0]   bytes_arr [N];
   logic            odd_arr   [N];

   int total = 0;
   int bad   = 0;
   int m_ptr = 0;

   // Transmitter model: 0 = never busy, 1 = normal frames, 2 = busy after xm_raise_at enables.
   int              xm_mode = 1;
   int              xm_raise_at = 0;
   int              xm_wait = 0;
   int              xm_left = 0;
   int              xm_en_cnt = 0;
   logic [DW-1:0]   line_byte = '0;
   logic            line_odd = 1'b0;
   int              line_frames = 0;
   int              fd_count = 0;
   int              to_count = 0;

   assign req_data = {bytes_arr[3], bytes_arr[2], bytes_arr[1], bytes_arr[0]};
   assign req_odd  = {odd_arr[3], odd_arr[2], odd_arr[1], odd_arr[0]};

   uart_tx_arbiter #(
      .NUM_REQ     (N),
      .DATA_W      (DW),
      .ACK_TIMEOUT (ACK),
      .GAP_CYCLES  (GAP)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_odd     (req_odd),
      .req_ready   (req_ready),
      .tx_enable   (tx_enable),
      .tx_data     (tx_data),
      .even_odd    (even_odd),
      .busy_tx     (busy_tx),
      .grant_id    (grant_id),
      .frame_done  (frame_done),
      .timeout_err (timeout_err)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge frame_done) fd_count++;
   always @(posedge timeout_err) to_count++;

   always @(negedge sys_clk) begin
      if (!rst) begin
         busy_tx   = 1'b0;
         xm_wait   = 0;
         xm_left   = 0;
         xm_en_cnt = 0;
      end else begin
         if (tx_enable === 1'b1) xm_en_cnt++;
         else xm_en_cnt = 0;
         case (xm_mode)
            1: begin
               if (busy_tx) begin
                  if (xm_left > 1) xm_left--;
                  else busy_tx = 1'b0;
               end else if (xm_wait > 0) begin
                  xm_wait--;
                  if (xm_wait == 0) begin
                     busy_tx   = 1'b1;
                     xm_left   = FRAME;
                     line_byte = tx_data;
                     line_odd  = even_odd;
                     line_frames++;
                  end
               end else if (tx_enable === 1'b1) begin
                  xm_wait = $urandom_range(1, 12);
               end
            end
            2: begin
               if (busy_tx) begin
                  if (xm_left > 1) xm_left--;
                  else busy_tx = 1'b0;
               end else if (xm_en_cnt == xm_raise_at) begin
                  busy_tx = 1'b1;
                  xm_left = FRAME;
               end
            end
            default: busy_tx = 1'b0;
         endcase
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference arbitration: requester with the smallest cyclic distance from the pointer.
   function automatic int pick(input logic [N-1:0] vec, input int ptr);
      int best;
      int best_dist;
      int d;
      best = -1;
      best_dist = N;
      for (int i = 0; i < N; i++) begin
         d = (i - ptr + N) % N;
         if (vec[i] && d < best_dist) begin
            best = i;
            best_dist = d;
         end
      end
      return best;
   endfunction

   task automatic wait_ready(input int limit, output int idx, output int cycles, output bit ok);
      ok = 1'b0;
      idx = -1;
      cycles = 0;
      for (int c = 1; c <= limit; c++) begin
         @(negedge sys_clk);
         if (req_ready !== '0) begin
            for (int i = N - 1; i >= 0; i--) if (req_ready[i]) idx = i;
            cycles = c;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_sig(input int which, input int limit, output int cycles, output bit ok);
      bit hit;
      ok = 1'b0;
      cycles = 0;
      for (int c = 1; c <= limit; c++) begin
         @(negedge sys_clk);
         case (which)
            SigTxEn:  hit = (tx_enable === 1'b1);
            SigTxLow: hit = (tx_enable === 1'b0);
            SigFrame: hit = (frame_done === 1'b1);
            default:  hit = (timeout_err === 1'b1);
         endcase
         if (hit) begin
            ok = 1'b1;
            cycles = c;
            break;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      rst = 1'b0;
      req_valid = '0;
      repeat (3) @(negedge sys_clk);
      rst = 1'b1;
      m_ptr = 0;
      @(negedge sys_clk);
   endtask

   // Serve every pending request, checking grant order and the byte on the line.
   task automatic serve_all(input string tag);
      int  idx, cyc, exp, lf0;
      bit  ok;
      while (req_valid != '0) begin
         exp = pick(req_valid, m_ptr);
         lf0 = line_frames;
         wait_ready(300, idx, cyc, ok);
         total++;
         if (!ok || idx != exp || req_ready !== (4'b0001 << exp)) begin
            bad++;
            $display("FAIL %s_grant: got ready=%b want req %0d", tag, req_ready, exp);
            return;
         end
         total++;
         if (grant_id !== 2'(exp)) begin
            bad++;
            $display("FAIL %s_grant_id: got %0d want %0d", tag, grant_id, exp);
         end
         req_valid = req_valid & ~(4'b0001 << idx);
         m_ptr = (exp + 1) % N;
         wait_sig(SigFrame, 300, cyc, ok);
         total++;
         if (!ok || line_byte !== bytes_arr[exp] || line_odd !== odd_arr[exp]
             || line_frames != lf0 + 1) begin
            bad++;
            $display("FAIL %s_line: got ok=%0d byte=%h odd=%b frames=%0d want byte=%h odd=%b frames=%0d",
                     tag, ok, line_byte, line_odd, line_frames - lf0, bytes_arr[exp], odd_arr[exp], 1);
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin
         bytes_arr[i] = '0;
         odd_arr[i] = 1'b0;
      end
      rst = 1'b0;
      repeat (3) @(negedge sys_clk);
      total++;
      if ({req_ready, tx_enable, tx_data, even_odd, grant_id, frame_done, timeout_err} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got ready=%b en=%b data=%h odd=%b gid=%0d fd=%b to=%b want all 0",
                  req_ready, tx_enable, tx_data, even_odd, grant_id, frame_done, timeout_err);
      end
      rst = 1'b1;
      repeat (4) @(negedge sys_clk);
      total++;
      if ({req_ready, tx_enable, frame_done, timeout_err} !== '0) begin
         bad++;
         $display("FAIL idle_quiet: got ready=%b en=%b fd=%b to=%b want all 0",
                  req_ready, tx_enable, frame_done, timeout_err);
      end
   endtask

   task automatic test_single();
      int idx, cyc, to0;
      bit ok;
      xm_mode = 1;
      to0 = to_count;
      bytes_arr[2] = 8'hA5;
      odd_arr[2] = 1'b1;
      req_valid = 4'b0100;
      wait_ready(10, idx, cyc, ok);
      total++;
      if (!ok || idx != 2 || cyc != 1 || req_ready !== 4'b0100 || grant_id !== 2'd2) begin
         bad++;
         $display("FAIL single_grant: got idx=%0d cyc=%0d ready=%b gid=%0d want 2 1 0100 2",
                  idx, cyc, req_ready, grant_id);
      end
      req_valid = '0;
      m_ptr = 3;
      wait_sig(SigTxEn, 4, cyc, ok);
      total++;
      if (!ok || cyc != 1 || tx_data !== 8'hA5 || even_odd !== 1'b1 || req_ready !== '0) begin
         bad++;
         $display("FAIL single_start: got cyc=%0d data=%h odd=%b ready=%b want 1 a5 1 0000",
                  cyc, tx_data, even_odd, req_ready);
      end
      wait_sig(SigFrame, 200, cyc, ok);
      total++;
      if (!ok || line_byte !== 8'hA5 || line_odd !== 1'b1 || grant_id !== 2'd2
          || tx_data !== 8'hA5 || tx_enable !== 1'b0) begin
         bad++;
         $display("FAIL single_frame: got ok=%0d line=%h odd=%b gid=%0d data=%h en=%b",
                  ok, line_byte, line_odd, grant_id, tx_data, tx_enable);
      end
      @(negedge sys_clk);
      total++;
      if (frame_done !== 1'b0 || to_count != to0) begin
         bad++;
         $display("FAIL single_pulse: got fd=%b timeouts=%0d want 0 0", frame_done, to_count - to0);
      end
   endtask

   task automatic test_contention();
      logic [N-1:0] vec;
      do_reset();
      for (int i = 0; i < N; i++) begin
         bytes_arr[i] = 8'(8'h10 + i);
         odd_arr[i] = 1'($urandom_range(0, 1));
      end
      req_valid = 4'b1111;
      serve_all("contend_all");
      bytes_arr[1] = 8'($urandom);
      bytes_arr[3] = 8'($urandom);
      req_valid = 4'b1010;
      serve_all("contend_1_3");
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++) begin
            bytes_arr[i] = 8'($urandom);
            odd_arr[i] = 1'($urandom_range(0, 1));
         end
         vec = 4'($urandom_range(1, 15));
         req_valid = vec;
         serve_all("random");
      end
   endtask

   task automatic test_timeout();
      int idx, cyc, fd0;
      bit ok;
      xm_mode = 0;
      fd0 = fd_count;
      bytes_arr[0] = 8'h3C;
      req_valid = 4'b0001;
      wait_ready(100, idx, cyc, ok);
      total++;
      if (!ok || idx != pick(4'b0001, m_ptr)) begin
         bad++;
         $display("FAIL tmo_grant: got idx=%0d want 0", idx);
      end
      req_valid = '0;
      m_ptr = 1;
      wait_sig(SigTxEn, 4, cyc, ok);
      wait_sig(SigTmo, 200, cyc, ok);
      total++;
      if (!ok || cyc != ACK || tx_enable !== 1'b0) begin
         bad++;
         $display("FAIL tmo_latency: got cyc=%0d en=%b want %0d 0", cyc, tx_enable, ACK);
      end
      xm_mode = 1;
      bytes_arr[2] = 8'hC3;
      odd_arr[2] = 1'b0;
      req_valid = 4'b0100;
      wait_ready(100, idx, cyc, ok);
      total++;
      if (!ok || idx != 2 || cyc != GAP + 1 || timeout_err !== 1'b0 || fd_count != fd0) begin
         bad++;
         $display("FAIL tmo_recover: got idx=%0d cyc=%0d to=%b fd=%0d want 2 %0d 0 0",
                  idx, cyc, timeout_err, fd_count - fd0, GAP + 1);
      end
      req_valid = '0;
      m_ptr = 3;
      wait_sig(SigFrame, 200, cyc, ok);
      total++;
      if (!ok || line_byte !== 8'hC3 || line_odd !== 1'b0) begin
         bad++;
         $display("FAIL tmo_next_frame: got ok=%0d byte=%h odd=%b want c3 0", ok, line_byte, line_odd);
      end
   endtask

   task automatic test_back_to_back();
      int idx, cyc;
      bit ok;
      xm_mode = 1;
      for (int k = 1; k <= 3; k++) begin
         bytes_arr[0] = 8'(k);
         odd_arr[0] = 1'(k % 2);
         req_valid = 4'b0001;
         wait_ready(300, idx, cyc, ok);
         total++;
         if (!ok || idx != 0 || (k > 1 && cyc != GAP + 1)) begin
            bad++;
            $display("FAIL b2b_ready_%0d: got idx=%0d cyc=%0d want 0 %0d", k, idx, cyc, GAP + 1);
         end
         req_valid = '0;
         m_ptr = 1;
         wait_sig(SigTxEn, 4, cyc, ok);
         total++;
         if (!ok || cyc != 1) begin
            bad++;
            $display("FAIL b2b_enable_%0d: got cyc=%0d want 1", k, cyc);
         end
         wait_sig(SigFrame, 200, cyc, ok);
         total++;
         if (!ok || line_byte !== 8'(k) || line_odd !== 1'(k % 2)) begin
            bad++;
            $display("FAIL b2b_line_%0d: got ok=%0d byte=%h want %h", k, ok, line_byte, 8'(k));
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      int idx, cyc, fd0;
      bit ok;
      xm_mode = 1;
      bytes_arr[2] = 8'h80 | 8'($urandom);
      odd_arr[2] = 1'b1;
      req_valid = 4'b0100;
      wait_ready(300, idx, cyc, ok);
      req_valid = '0;
      wait_sig(SigTxEn, 4, cyc, ok);
      wait_sig(SigTxLow, 60, cyc, ok);
      total++;
      if (!ok || idx != pick(4'b0100, m_ptr)) begin
         bad++;
         $display("FAIL rstbusy_setup: got ok=%0d idx=%0d want 1 2", ok, idx);
      end
      repeat (2) @(negedge sys_clk);
      fd0 = fd_count;
      bytes_arr[1] = 8'($urandom);
      bytes_arr[3] = 8'($urandom);
      req_valid = 4'b1010;
      @(negedge sys_clk);
      rst = 1'b0;
      #1;
      total++;
      if ({req_ready, tx_enable, tx_data, even_odd, grant_id, frame_done, timeout_err} !== '0) begin
         bad++;
         $display("FAIL rstbusy_async: got en=%b data=%h odd=%b gid=%0d want all 0",
                  tx_enable, tx_data, even_odd, grant_id);
      end
      repeat (3) @(negedge sys_clk);
      total++;
      if ({req_ready, tx_enable, frame_done} !== '0 || fd_count != fd0) begin
         bad++;
         $display("FAIL rstbusy_hold: got ready=%b en=%b frames=%0d want 0", req_ready, tx_enable,
                  fd_count - fd0);
      end
      rst = 1'b1;
      m_ptr = 0;
      serve_all("rstbusy");
   endtask

   task automatic test_simultaneous();
      int idx, cyc, fd0, to0;
      bit ok;
      for (int pass = 0; pass < 2; pass++) begin
         xm_mode = 2;
         xm_raise_at = 62 + pass;
         fd0 = fd_count;
         to0 = to_count;
         req_valid = 4'b1000;
         wait_ready(300, idx, cyc, ok);
         total++;
         if (!ok || idx != pick(4'b1000, m_ptr)) begin
            bad++;
            $display("FAIL simul_grant_%0d: got idx=%0d want 3", pass, idx);
         end
         req_valid = '0;
         m_ptr = 0;
         repeat (ACK + FRAME + GAP + 30) @(negedge sys_clk);
         total++;
         if (to_count - to0 != pass || fd_count - fd0 != 1 - pass) begin
            bad++;
            $display("FAIL simul_edge_%0d: got timeouts=%0d frames=%0d want %0d %0d",
                     pass, to_count - to0, fd_count - fd0, pass, 1 - pass);
         end
      end
      xm_mode = 1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_timeout();
      test_back_to_back();
      test_reset_mid_busy();
      test_simultaneous();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares one `transmitter` instance between several byte producers. It accepts bytes over per-requester valid/ready handshakes and drives the transmitter's `tx_enable`, `tx_data` and `even_odd` inputs. It paces each frame by watching the transmitter's `busy` output, and flags frames the transmitter never starts. It sits between client logic and `transmitter` inside `UART`-level integrations, on `sys_clk`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width; fixed by `transmitter`.
- `ACK_TIMEOUT`, 256: `sys_clk` cycles to wait for `busy` to rise after `tx_enable`.
- `GAP_CYCLES`, 32: idle `sys_clk` cycles inserted after each frame, minimum 1.
- `sys_clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: requester i has a byte pending.
- `req_data` in NUM_REQ*DATA_W: byte of requester i at bits [i*8+7:i*8].
- `req_odd` in NUM_REQ: parity mode of requester i; forwarded to `even_odd`.
- `req_ready` out NUM_REQ: one-hot, 1-cycle pulse; the byte of requester i is taken.
- `tx_enable` out 1: to `transmitter.tx_enable`.
- `tx_data` out DATA_W: to `transmitter.tx_data`.
- `even_odd` out 1: to `transmitter.even_odd`.
- `busy_tx` in 1: from `transmitter.busy`; treated as asynchronous.
- `grant_id` out clog2(NUM_REQ): index of the current or last granted requester.
- `frame_done` out 1: 1-cycle pulse when `busy` falls for a granted frame.
- `timeout_err` out 1: 1-cycle pulse when `ACK_TIMEOUT` expires.

## Operation
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, counters 0.
- `busy_tx` passes through a 2-flop synchronizer; `busy_s` is the synchronized signal.
- The FSM has five states:
  - IDLE: if any `req_valid` is set, the winner is the first set bit at or after the pointer, searching cyclically. The winner is registered into `grant_id`, and the next state is GRANT. Otherwise stay in IDLE.
  - GRANT, 1 cycle: `req_ready[grant_id]`=1. `tx_data`/`even_odd` capture `req_data`/`req_odd` of `grant_id` on this edge. The pointer becomes `grant_id`+1, modulo NUM_REQ. The next state is START.
  - START: `tx_enable`=1 and the timeout counter increments.
    - `busy_s`=1 → BUSY, with `tx_enable` 0 from the next cycle.
    - Counter reaches ACK_TIMEOUT-1 → `timeout_err` pulse and go to GAP. The byte is dropped, not retried.
  - BUSY: `tx_enable`=0. When `busy_s`=0, pulse `frame_done` and go to GAP.
  - GAP: count GAP_CYCLES, then go to IDLE.
- `tx_data`/`even_odd` hold their captured values from GRANT until the next GRANT.
- Requesters must hold `req_valid` and data stable until `req_ready`. Dropping `req_valid` before `req_ready` is allowed only while the FSM is not in GRANT for that requester.
- `req_valid` is ignored in every state except IDLE.
- `req_ready` is never asserted for a requester whose `req_valid` was 0 in the preceding IDLE cycle.
- The timeout counter is `$clog2(ACK_TIMEOUT)+1` bits wide and cleared on entry to START.
- The GAP counter is sized for GAP_CYCLES and cleared on entry to GAP.

## Timing
- Minimum latency from `req_valid` in IDLE to `req_ready` is 1 cycle: IDLE samples, GRANT pulses.
- `tx_enable` rises on the cycle after GRANT.
- `transmitter` samples `tx_enable` on `baud_clk`, whose period is 2×(sys_clk_freq/baud_rate) `sys_clk` cycles, 32 at the defaults. `busy_s` therefore rises 3..35 cycles after `tx_enable`.
  - ACK_TIMEOUT must exceed baud period + 3.
- Frame slot in `sys_clk` cycles = 1 (GRANT) + START + BUSY + GAP_CYCLES + 1 (IDLE decision).
- Busy glitch: if `busy_s` falls while in START, it is ignored. Only a rise exits START.
- Simultaneous timeout expiry and `busy_s` rise in START: the busy rise wins, with no `timeout_err`.
- Reset mid-frame clears the FSM immediately and drops the captured byte; no `frame_done` is generated. The transmitter is reset by the same top-level reset.
- Pointer wrap: grant of NUM_REQ-1 sets the pointer to 0.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE=0, GRANT=1, START=2, BUSY=3, GAP=4) on 3 bits.
  - `UART_DATA_W`=8.
  - Default `ACK_TIMEOUT` and `GAP_CYCLES` constants.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs: request vector and pointer. Outputs: `any` and winner index. Parameterized by NUM_REQ.
- FSM, synchronizer, counters and capture registers live in `uart_tx_arbiter`.

## Test plan
- Single request: req 2 `valid` with 0xA5, `req_odd`=1 → `req_ready[2]` pulse 1 cycle later. `tx_data`=0xA5, `even_odd`=1, `tx_enable` until `busy` rises, then one `frame_done`. The serial line carries 0xA5 and `grant_id`=2.
- Contention: all four valid with 0x10..0x13, held until `ready` → grants in order 0,1,2,3. Then, with the pointer at 0, req 1 and req 3 re-requesting → 1 then 3.
- Timeout: `busy_tx` tied 0, ACK_TIMEOUT=64 → `timeout_err` exactly 64 cycles after `tx_enable` rises, then GAP, then IDLE. The next request is served normally.
- Back-to-back on one requester: req 0 streams 0x01,0x02,0x03 → three frames, each separated by at least GAP_CYCLES with `tx_enable` low.
- Reset mid-BUSY: `rst` low for 3 cycles during a frame → all outputs 0 asynchronously, pointer 0. After release, a pending req 1 is granted first.
- Simultaneous edge: `busy_s` rise forced on the timeout expiry cycle → BUSY entered, no `timeout_err`.
